// File: rtl/riscv_sequencer.sv
// Multi-cycle RV32I control FSM: fetch/decode/execute/mem/writeback sequencing,
// memory-port handshake and retired-instruction count. Optional macro: TRAP_ILLEGAL_EN.
module riscv_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [6:0]       opcode,
    input  logic [2:0]       funct3,
    input  logic             branch_taken,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_we,
    output logic             mem_addr_sel,
    output logic             ir_load,
    output logic             pc_load,
    output logic [1:0]       pc_src,
    output logic             alu_src_a,
    output logic             alu_src_b,
    output logic             reg_we,
    output logic [1:0]       wb_sel,
    output logic [31:0]      pc_reset_val,
    output logic [2:0]       state,
    output logic             halted,
    output logic [CNT_W-1:0] instret
);

    localparam logic [2:0] S_FETCH = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXECUTE = 3'd2;
    localparam logic [2:0] S_MEM = 3'd3;
    localparam logic [2:0] S_WRITEBACK = 3'd4;
    localparam logic [2:0] S_HALT = 3'd5;
    localparam logic [2:0] S_TRAP = 3'd6;

    localparam logic [6:0] OP_OP = 7'h33;
    localparam logic [6:0] OP_IMM = 7'h13;
    localparam logic [6:0] OP_LUI = 7'h37;
    localparam logic [6:0] OP_AUIPC = 7'h17;
    localparam logic [6:0] OP_LOAD = 7'h03;
    localparam logic [6:0] OP_STORE = 7'h23;
    localparam logic [6:0] OP_JAL = 7'h6F;
    localparam logic [6:0] OP_JALR = 7'h67;
    localparam logic [6:0] OP_BRANCH = 7'h63;
    localparam logic [6:0] OP_SYSTEM = 7'h73;

    logic [2:0]       state_q, state_d;
    logic [6:0]       op_q, op_d;
    logic             halted_q, halted_d;
    logic [CNT_W-1:0] instret_q, instret_d;
    logic             is_halt_sys;
    logic             wb_writes;

    function automatic logic is_known(input logic [6:0] op);
        is_known = (op == OP_OP) || (op == OP_IMM) || (op == OP_LUI) ||
                   (op == OP_AUIPC) || (op == OP_LOAD) || (op == OP_STORE) ||
                   (op == OP_JAL) || (op == OP_JALR) || (op == OP_BRANCH);
    endfunction

    // Only the ECALL/EBREAK group stops the core; other SYSTEM encodings are unsupported.
    assign is_halt_sys = (opcode == OP_SYSTEM) && (funct3 == 3'd0);
    assign wb_writes   = is_known(op_q) && (op_q != OP_STORE) && (op_q != OP_BRANCH);

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        unique case (state_q)
            S_FETCH: begin
                if (mem_ready) begin
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                op_d = opcode;
                if (is_halt_sys) begin
                    state_d = S_HALT;
                end else begin
`ifdef TRAP_ILLEGAL_EN
                    state_d = is_known(opcode) ? S_EXECUTE : S_TRAP;
`else
                    state_d = S_EXECUTE;
`endif
                end
            end
            S_EXECUTE: begin
                if (op_q == OP_BRANCH) begin
                    state_d = S_FETCH;
                end else if ((op_q == OP_LOAD) || (op_q == OP_STORE)) begin
                    state_d = S_MEM;
                end else begin
                    state_d = S_WRITEBACK;
                end
            end
            S_MEM: begin
                if (mem_ready) begin
                    state_d = (op_q == OP_LOAD) ? S_WRITEBACK : S_FETCH;
                end
            end
            S_WRITEBACK: state_d = S_FETCH;
            S_HALT:      state_d = S_HALT;
            S_TRAP:      state_d = S_TRAP;
            default:     state_d = S_FETCH;
        endcase
    end

    always_comb begin
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr_sel = 1'b0;
        ir_load      = 1'b0;
        pc_load      = 1'b0;
        pc_src       = 2'd0;
        alu_src_a    = 1'b0;
        alu_src_b    = 1'b0;
        reg_we       = 1'b0;
        wb_sel       = 2'd0;
        unique case (state_q)
            S_FETCH: begin
                mem_req = 1'b1;
                ir_load = mem_ready;
            end
            S_EXECUTE: begin
                alu_src_a = (op_q == OP_AUIPC);
                alu_src_b = (op_q == OP_IMM) || (op_q == OP_AUIPC) ||
                            (op_q == OP_LOAD) || (op_q == OP_STORE);
                if (op_q == OP_BRANCH) begin
                    pc_load = 1'b1;
                    pc_src  = branch_taken ? 2'd3 : 2'd0;
                end
            end
            S_MEM: begin
                mem_req      = 1'b1;
                mem_addr_sel = 1'b1;
                mem_we       = (op_q == OP_STORE);
                alu_src_b    = 1'b1;
                pc_load      = (op_q == OP_STORE) && mem_ready;
            end
            S_WRITEBACK: begin
                reg_we  = wb_writes;
                pc_load = 1'b1;
                if (op_q == OP_LOAD) begin
                    wb_sel = 2'd1;
                end else if ((op_q == OP_JAL) || (op_q == OP_JALR)) begin
                    wb_sel = 2'd2;
                end else if (op_q == OP_LUI) begin
                    wb_sel = 2'd3;
                end
                if (op_q == OP_JAL) begin
                    pc_src = 2'd1;
                end else if (op_q == OP_JALR) begin
                    pc_src = 2'd2;
                end
            end
            default: ;
        endcase
        // Reset abandons any in-flight access: every strobe and select goes quiet.
        if (reset) begin
            mem_req      = 1'b0;
            mem_we       = 1'b0;
            mem_addr_sel = 1'b0;
            ir_load      = 1'b0;
            pc_load      = 1'b0;
            pc_src       = 2'd0;
            alu_src_a    = 1'b0;
            alu_src_b    = 1'b0;
            reg_we       = 1'b0;
            wb_sel       = 2'd0;
        end
    end

    assign halted_d  = (state_d == S_HALT) || (state_d == S_TRAP);
    assign instret_d = pc_load ? instret_q + {{(CNT_W-1){1'b0}}, 1'b1} : instret_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= S_FETCH;
            op_q      <= 7'd0;
            halted_q  <= 1'b0;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            halted_q  <= halted_d;
            instret_q <= instret_d;
        end
    end

    assign pc_reset_val = RESET_PC;
    assign state        = state_q;
    assign halted       = halted_q;
    assign instret      = instret_q;

endmodule

// File: tb/tb_riscv_sequencer.sv
// Scoreboard bench for riscv_sequencer: a memory model with programmable wait
// states drives each instruction; expected timing and strobes are queued per instruction.
module tb_riscv_sequencer;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [6:0]  opcode = 7'h13;
    logic [2:0]  funct3 = 3'd0;
    logic        branch_taken = 1'b0;
    logic        mem_ready = 1'b0;
    logic        mem_req, mem_we, mem_addr_sel, ir_load, pc_load;
    logic [1:0]  pc_src, wb_sel;
    logic        alu_src_a, alu_src_b, reg_we, halted;
    logic [31:0] pc_reset_val, instret;
    logic [2:0]  state;

    int total = 0;
    int bad = 0;
    int m_instret = 0;

    typedef struct {
        int cyc; int rw; int wb; int ps; int we; int fc; int mc; int sa; int sb; int ir;
    } exp_t;
    exp_t sbq[$];

    riscv_sequencer dut (
        .clock(clock), .reset(reset), .opcode(opcode), .funct3(funct3),
        .branch_taken(branch_taken), .mem_ready(mem_ready), .mem_req(mem_req),
        .mem_we(mem_we), .mem_addr_sel(mem_addr_sel), .ir_load(ir_load),
        .pc_load(pc_load), .pc_src(pc_src), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .reg_we(reg_we), .wb_sel(wb_sel),
        .pc_reset_val(pc_reset_val), .state(state), .halted(halted), .instret(instret)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [6:0] op, input logic tk, input int fw, input int mw);
        exp_t e;
        bit ismem;
        ismem = (op == 7'h03) || (op == 7'h23);
        e.cyc = (op == 7'h63) ? 3 : (op == 7'h03) ? 5 : 4;
        e.cyc = e.cyc + fw + (ismem ? mw : 0);
        e.rw  = (op == 7'h33 || op == 7'h13 || op == 7'h37 || op == 7'h17 ||
                 op == 7'h03 || op == 7'h6F || op == 7'h67) ? 1 : 0;
        e.wb  = (op == 7'h03) ? 1 : (op == 7'h6F || op == 7'h67) ? 2 : (op == 7'h37) ? 3 : 0;
        e.ps  = (op == 7'h6F) ? 1 : (op == 7'h67) ? 2 : (op == 7'h63) ? (tk ? 3 : 0) : 0;
        e.we  = (op == 7'h23) ? 1 : 0;
        e.fc  = fw + 1;
        e.mc  = ismem ? mw + 1 : 0;
        e.sa  = (op == 7'h17) ? 1 : 0;
        e.sb  = (op == 7'h13 || op == 7'h17 || op == 7'h03 || op == 7'h23) ? 1 : 0;
        e.ir  = 0;
        return e;
    endfunction

    // Runs one instruction from the first FETCH cycle to its pc_load cycle.
    task automatic exec(input logic [6:0] op, input logic tk, input int fw, input int mw,
                        input string tag);
        exp_t e;
        int cyc, rwn, rwc, wbs, pss, wes, fc, mc, sa, sb;
        bit done, pend, drop;
        e = model(op, tk, fw, mw);
        m_instret++;
        e.ir = m_instret;
        sbq.push_back(e);
        opcode = op; funct3 = 3'd0; branch_taken = tk;
        cyc = 0; rwn = 0; rwc = 0; wbs = 0; pss = 0; wes = 0; fc = 0; mc = 0;
        sa = 0; sb = 0; done = 0; pend = 0; drop = 0;
        while (!done && cyc < 64) begin
            @(negedge clock);
            if (mem_req && !mem_addr_sel) begin
                mem_ready = (fc >= fw); fc++;
            end else if (mem_req) begin
                mem_ready = (mc >= mw); mc++;
            end else begin
                mem_ready = 1'b0;
            end
            #1;
            cyc++;
            if (pend && !mem_req) drop = 1;
            pend = mem_req && !mem_ready;
            if (mem_we) wes = 1;
            if (state == 3'd2) begin sa = alu_src_a; sb = alu_src_b; end
            if (reg_we) begin rwn++; rwc = cyc; wbs = wb_sel; end
            if (pc_load) begin pss = pc_src; done = 1; end
        end
        if (!done) chk({tag, ".timeout"}, 0, 1);
        @(posedge clock);
        #1;
        mem_ready = 1'b0;
        e = sbq.pop_front();
        chk({tag, ".cycles"}, cyc, e.cyc);
        chk({tag, ".reg_we_n"}, rwn, e.rw);
        if (e.rw != 0) begin
            chk({tag, ".reg_we_cyc"}, rwc, e.cyc);
            chk({tag, ".wb_sel"}, wbs, e.wb);
        end
        chk({tag, ".pc_src"}, pss, e.ps);
        chk({tag, ".mem_we"}, wes, e.we);
        chk({tag, ".fetch_req"}, fc, e.fc);
        chk({tag, ".mem_req"}, mc, e.mc);
        chk({tag, ".src_a"}, sa, e.sa);
        chk({tag, ".src_b"}, sb, e.sb);
        chk({tag, ".req_drop"}, drop, 0);
        chk({tag, ".instret"}, instret, e.ir);
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1; mem_ready = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        m_instret = 0;
    endtask

    // Stops the core with op and checks it stays stopped with no memory traffic.
    task automatic halt_test(input logic [6:0] op, input logic [2:0] st, input string tag);
        int nreq, hc;
        opcode = op; funct3 = 3'd0;
        nreq = 0; hc = 0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clock);
            mem_ready = mem_req;
            #1;
            if (mem_req) nreq++;
            if (halted && hc == 0) hc = i;
        end
        mem_ready = 1'b0;
        chk({tag, ".req_n"}, nreq, 1);
        chk({tag, ".halt_cyc"}, hc, 3);
        chk({tag, ".halted"}, halted, 1);
        chk({tag, ".state"}, state, st);
        chk({tag, ".instret"}, instret, m_instret);
        chk({tag, ".pc_load"}, pc_load, 0);
    endtask

    initial begin
        logic [6:0] ops [9] = '{7'h33, 7'h13, 7'h37, 7'h17, 7'h03, 7'h23, 7'h6F, 7'h67, 7'h63};
        repeat (3) @(posedge clock);
        #1;
        chk("rst.state", state, 0);
        chk("rst.instret", instret, 0);
        chk("rst.halted", halted, 0);
        chk("rst.mem_req", mem_req, 0);
        chk("rst.pc_rst_val", pc_reset_val, 32'h0);
        @(negedge clock);
        reset = 1'b0;
        #1;
        chk("rel.mem_req", mem_req, 1);

        exec(7'h13, 0, 0, 0, "addi");
        exec(7'h33, 0, 0, 0, "add");
        exec(7'h03, 0, 3, 2, "ld_wait");
        exec(7'h63, 1, 0, 0, "br_t");
        exec(7'h63, 0, 0, 0, "br_nt");
        exec(7'h6F, 0, 0, 0, "jal");
        exec(7'h67, 0, 0, 0, "jalr");
        exec(7'h23, 0, 0, 0, "st");
        exec(7'h23, 0, 1, 2, "st_wait");
        exec(7'h37, 0, 0, 0, "lui");
        exec(7'h17, 0, 2, 0, "auipc");
        exec(7'h03, 0, 0, 0, "ld");
        for (int i = 0; i < 12; i++) begin
            exec(ops[$urandom_range(0, 8)], 1'($urandom_range(0, 1)),
                 $urandom_range(0, 3), $urandom_range(0, 3), "rnd");
        end

`ifdef TRAP_ILLEGAL_EN
        halt_test(7'h7F, 3'd6, "trap");
        do_reset();
        exec(7'h13, 0, 0, 0, "post_trap");
`else
        exec(7'h7F, 0, 0, 0, "nop");
`endif

        // Reset while a load sits in a MEM wait.
        opcode = 7'h03; funct3 = 3'd0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            mem_ready = mem_req && !mem_addr_sel;
        end
        #1;
        chk("midrst.pre_state", state, 3);
        chk("midrst.pre_sel", mem_addr_sel, 1);
        @(negedge clock);
        reset = 1'b1; mem_ready = 1'b1;
        #1;
        chk("midrst.mem_req", mem_req, 0);
        chk("midrst.pc_load", pc_load, 0);
        chk("midrst.ir_load", ir_load, 0);
        @(posedge clock);
        #1;
        chk("midrst.state", state, 0);
        chk("midrst.instret", instret, 0);
        @(negedge clock);
        reset = 1'b0; mem_ready = 1'b0;
        m_instret = 0;
        #1;
        chk("midrst.fetch", mem_req, 1);
        chk("midrst.fetch_sel", mem_addr_sel, 0);
        exec(7'h13, 0, 0, 0, "post_rst");

        halt_test(7'h73, 3'd5, "halt");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/riscv_sequencer.md
Name: riscv_sequencer

Overview:
Multi-cycle control FSM for the RV32I core. Consumes the decoded opcode/funct3 plus datapath status, and drives the strobes and selects for PC, instruction register, register file, ALU operand muxes and the shared instruction/data memory port. Sits between the instruction decoder and the datapath. Owns the single memory port handshake and the retired-instruction count.

Parameters:
RESET_PC, 32'h0000_0000, value reported on pc_reset_val; datapath loads PC from it while reset is high
CNT_W, 32, width of instret counter

Ports:
clock  in  1  system clock, all state updates on rising edge
reset  in  1  synchronous, active-high reset
opcode  in  7  from decoder, valid while ir holds the current instruction
funct3  in  3  from decoder (SYSTEM: 0 = ECALL/EBREAK group)
branch_taken  in  1  datapath branch-compare result, valid in EXECUTE
mem_ready  in  1  memory completes the current request this cycle
mem_req  out  1  memory request, held until mem_ready
mem_we  out  1  write qualifier for mem_req (store)
mem_addr_sel  out  1  0 = PC, 1 = ALU result
ir_load  out  1  capture fetched word into IR
pc_load  out  1  update PC; exactly one pulse per retired instruction
pc_src  out  2  0 = PC+4, 1 = JAL target, 2 = JALR target, 3 = branch target
alu_src_a  out  1  0 = rs1, 1 = PC
alu_src_b  out  1  0 = rs2, 1 = immediate
reg_we  out  1  register-file write strobe
wb_sel  out  2  0 = ALU, 1 = load data, 2 = PC+4, 3 = imm20<<12
pc_reset_val  out  32  constant RESET_PC
state  out  3  current state, debug
halted  out  1  core stopped
instret  out  CNT_W  retired-instruction count

Behaviour:
- States: FETCH=0, DECODE=1, EXECUTE=2, MEM=3, WRITEBACK=4, HALT=5, TRAP=6.
- Reset, sampled on a clock edge: state <- FETCH, instret <- 0, halted <- 0. While reset is high, every strobe (mem_req, mem_we, ir_load, pc_load, reg_we) is forced 0. Selects are 0. Reset mid-request abandons the access, and the first cycle after reset drops is a fresh FETCH.
- Outputs are Moore decodes of state plus the latched opcode. The only exception is that ir_load and pc_load in wait states are qualified by mem_ready.
- FETCH: mem_req=1, mem_addr_sel=0, mem_we=0. When mem_ready=1, ir_load=1 and the next state is DECODE; otherwise the FSM stays in FETCH. A zero-wait ready in the same cycle as the request is legal.
- DECODE: one cycle for register read. Next state is EXECUTE, except SYSTEM goes to HALT.
- EXECUTE, by opcode:
  - OP 0x33: src_b=0, next state WRITEBACK.
  - OP_IMM 0x13: src_b=1, next state WRITEBACK.
  - LUI 0x37: next state WRITEBACK.
  - AUIPC 0x17: src_a=1, src_b=1, next state WRITEBACK.
  - LOAD 0x03 / STORE 0x23: src_b=1 (address), next state MEM.
  - JAL 0x6F / JALR 0x67: next state WRITEBACK.
  - BRANCH 0x63: pc_load=1 with pc_src = branch_taken ? 3 : 0, next state FETCH.
- MEM: mem_req=1, mem_addr_sel=1, mem_we=1 for STORE. The FSM holds until mem_ready. Then LOAD goes to WRITEBACK; STORE asserts pc_load with pc_src=0 and goes to FETCH.
- WRITEBACK: reg_we=1 and pc_load=1, next state FETCH.
  - wb_sel: LOAD=1, JAL/JALR=2, LUI=3, otherwise 0.
  - pc_src: JAL=1, JALR=2, otherwise 0.
  - rd=x0 is not special-cased; the register file ignores writes to x0.
- instret increments on every pc_load pulse and wraps modulo 2^CNT_W without saturating.
- Latencies with zero-wait memory:
  - ALU/LUI/AUIPC/JAL/JALR: 4 cycles.
  - BRANCH: 3 cycles.
  - STORE: 4 cycles.
  - LOAD: 5 cycles.
  - Each memory wait cycle adds 1.
- HALT: halted=1, all strobes 0, the FSM stays in HALT until reset. The SYSTEM instruction is not counted in instret.
- mem_req must not drop before mem_ready within one access. mem_ready while mem_req=0 is ignored.

Optional Feature:
TRAP_ILLEGAL_EN
- Defined: an opcode outside the set above, sampled in DECODE, goes to TRAP. TRAP behaves as HALT (halted=1, strobes 0, sticky until reset), and state reads 6.
- Undefined: unknown opcodes execute as NOP through EXECUTE, then WRITEBACK with reg_we=0 and pc_load=1 (pc_src=0). They are counted in instret, and TRAP is unreachable.

Test Plan:
- Zero-wait ADDI then ADD -> each takes 4 cycles; reg_we pulses on cycles 4 and 8; instret=2; pc_src=0.
- LOAD with 3 wait cycles in FETCH and 2 in MEM -> total 10 cycles; mem_req continuous in each phase; mem_addr_sel 0 then 1; wb_sel=1 at reg_we.
- BRANCH taken vs not taken -> 3 cycles, reg_we never asserted, pc_src=3 vs 0 on the pc_load cycle.
- JAL then JALR -> WRITEBACK with wb_sel=2 and pc_src 1 then 2; STORE -> mem_we=1 in MEM, no reg_we.
- reset asserted during a MEM wait -> next cycle is FETCH with mem_req=0 during reset; instret=0; new fetch issued on release.
- opcode 0x73 -> halted=1 after DECODE, no further mem_req; with TRAP_ILLEGAL_EN, opcode 0x7F -> state=6, instret unchanged.
